// File: rtl/mem_arbiter.sv
// Purpose : shares one off-chip memory port between the I-cache (read-only) and D-cache (read/write), one transaction at a time.
// Latency : request in IDLE at T -> mem_read/mem_write registered high at T+1; mem_ready forwarded to the owner in the same cycle.
// Backpres: the losing client simply keeps its request held; each grant is followed by a one-cycle DONE gap before re-arbitration.
// Option  : define MEM_ARB_RR_EN for round-robin tie breaking; otherwise the D-cache wins every tie.
module mem_arbiter #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              proc_reset_n,
    // I-cache side
    input  logic              ic_mem_read,
    input  logic [ADDR_W-1:0] ic_mem_addr,
    output logic [DATA_W-1:0] ic_mem_rdata,
    output logic              ic_mem_ready,
    // D-cache side
    input  logic              dc_mem_read,
    input  logic              dc_mem_write,
    input  logic [ADDR_W-1:0] dc_mem_addr,
    input  logic [DATA_W-1:0] dc_mem_wdata,
    output logic [DATA_W-1:0] dc_mem_rdata,
    output logic              dc_mem_ready,
    // memory side
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              req_i;
    logic              req_d;
    logic              pick_d;
    logic              mem_read_nxt;
    logic              mem_write_nxt;
    logic [ADDR_W-1:0] mem_addr_nxt;
    logic [DATA_W-1:0] mem_wdata_nxt;

    assign req_i = ic_mem_read;
    assign req_d = dc_mem_read | dc_mem_write;

`ifdef MEM_ARB_RR_EN
    // 1 = D-cache was served last; reset value points at the I-cache so D wins the first tie.
    logic rr_last_d;

    assign pick_d = req_d & (~req_i | ~rr_last_d);

    // Record the client that is granted, at the moment the grant is taken.
    always_ff @(posedge clk or negedge proc_reset_n) begin
        if (!proc_reset_n) begin
            rr_last_d <= 1'b0;
        end else if ((state == IDLE) && (req_i || req_d)) begin
            rr_last_d <= pick_d;
        end
    end
`else
    // Fixed priority: the D-cache wins any tie.
    assign pick_d = req_d;
`endif

    // State and memory request registers; reset clears the port immediately.
    always_ff @(posedge clk or negedge proc_reset_n) begin
        if (!proc_reset_n) begin
            state     <= IDLE;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            state     <= state_nxt;
            mem_read  <= mem_read_nxt;
            mem_write <= mem_write_nxt;
            mem_addr  <= mem_addr_nxt;
            mem_wdata <= mem_wdata_nxt;
        end
    end

    // Next-state and request capture: load from the winner in IDLE, hold through the grant, drop on completion.
    always_comb begin
        state_nxt     = state;
        mem_read_nxt  = mem_read;
        mem_write_nxt = mem_write;
        mem_addr_nxt  = mem_addr;
        mem_wdata_nxt = mem_wdata;
        case (state)
            IDLE: begin
                if (req_i || req_d) begin
                    if (pick_d) begin
                        state_nxt     = GNT_D;
                        // a write-back takes precedence over a read raised in the same cycle
                        mem_write_nxt = dc_mem_write;
                        mem_read_nxt  = dc_mem_read & ~dc_mem_write;
                        mem_addr_nxt  = dc_mem_addr;
                        mem_wdata_nxt = dc_mem_wdata;
                    end else begin
                        state_nxt     = GNT_I;
                        mem_read_nxt  = 1'b1;
                        mem_write_nxt = 1'b0;
                        mem_addr_nxt  = ic_mem_addr;
                        mem_wdata_nxt = '0;
                    end
                end
            end
            GNT_I, GNT_D: begin
                if (mem_ready) begin
                    state_nxt     = DONE;
                    mem_read_nxt  = 1'b0;
                    mem_write_nxt = 1'b0;
                end
            end
            DONE: begin
                // the served cache may still show its request this cycle; never re-arbitrate here
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Read data is broadcast; only the completion strobe is steered to the owner.
    assign ic_mem_rdata = mem_rdata;
    assign dc_mem_rdata = mem_rdata;
    assign ic_mem_ready = (state == GNT_I) & mem_ready;
    assign dc_mem_ready = (state == GNT_D) & mem_ready;

endmodule
